card_draw_unit: RTL
===================

// Module: card_draw_unit
// PURPOSE
//  Upstream card source for the game-select mux and the blackjack/roulette FSMs.
//  Replaces a bare random number with a draw from a finite shoe.
//  On each key press it draws one card without replacement, using a free-running LFSR.
//  It reports the blackjack value on q and holds it until the next draw.
//  One instance is used per hand (player/dealer); its q feeds the mux's prandnum/drandnum.
// PARAMETERS
//  LFSR_SEED   16'hACE1  non-zero LFSR load value on reset
//  DECK_COUNT  1         decks in shoe (1..2); 4*DECK_COUNT cards per rank
//  MAX_TRIES   15        random attempts before deterministic fallback (1..15)
// PORTS
//  clock       in   1  system clock (CLOCK_50); single clock domain
//  reset_n     in   1  synchronous, active-low reset
//  enable      in   1  1 = LFSR advances every clock; 0 = LFSR frozen
//  load        in   1  active-low key; falling edge requests a draw
//  shuffle     in   1  active-high level; refills shoe
//  q           out  5  blackjack value of last card: rank 1..10 -> rank, 11..13 -> 10
//  rank        out  4  rank of last card, 1..13 (0 = none since reset)
//  card_valid  out  1  one-cycle pulse when q/rank update
//  busy        out  1  1 while in DRAW
//  deck_empty  out  1  1 when cards_left == 0
//  cards_left  out  7  cards remaining in shoe
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - q=0, rank=0, card_valid=0, busy=0, deck_empty=0.
//   - cards_left=52*DECK_COUNT; every rank count=4*DECK_COUNT; lfsr=LFSR_SEED; state=IDLE.
//   - Reset applied mid-DRAW aborts the draw; no card_valid is produced.
//  LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11; never reaches 0.
//  Inputs: load and shuffle each pass through a 2-FF synchronizer.
//   - load sync flops reset to 1 (released).
//   - press = prev_sync & ~sync: one pulse per press, however long the key is held.
//  FSM states IDLE, DRAW, EMPTY:
//   - IDLE: press & cards_left>0 -> DRAW, tries<=0, busy=1.
//   - DRAW, each cycle: cand = lfsr[3:0].
//     - Accept if 1<=cand<=13 and count[cand]>0.
//     - Otherwise tries++. At tries==MAX_TRIES, cand = lowest rank with count>0.
//     - Commit: count[cand]--, cards_left--, rank<=cand, q<=min(cand,10), card_valid=1.
//       Next state is IDLE, or EMPTY if cards_left becomes 0.
//   - EMPTY: deck_empty=1; press ignored; q/rank held.
//  Latency: press detect -> card_valid is 1..MAX_TRIES+1 cycles. Add 2 cycles of synchronizer delay from the load pin.
//  A press arriving while in DRAW is dropped, not queued.
//  Shuffle (sync level high, any state):
//   - All counts restored, cards_left=52*DECK_COUNT, deck_empty=0, state=IDLE, busy=0.
//   - q/rank held; LFSR not reseeded.
//   - Shuffle wins over press or commit in the same cycle; no card_valid.
//  enable=0 does not stall the FSM. A frozen LFSR value is retried, so the fallback path is used.
//  Widths: per-rank count 4 bits; cards_left 7 bits (max 104). q is zero-extended to 5 bits.
// STRUCTURE
//  Shared package card_pkg:
//   - state encoding (IDLE/DRAW/EMPTY), NUM_RANKS=13, FACE_VALUE=10, CARDS_PER_DECK=52.
//  Sub-module lfsr16: clock, reset_n, enable, seed -> 16-bit state.
//  Everything else lives in this module: synchronizers, edge detect, FSM, rank-count array,
//  and the lowest-available priority encoder.
// TESTING
//  1. Reset, seed ACE1, one 20-cycle press:
//     exactly one card_valid within 2+16 cycles; cards_left 52->51; 1<=rank<=13.
//  2. 52 presses with idle gaps:
//     each rank seen exactly 4 times; deck_empty=1 after the 52nd.
//     53rd press -> no card_valid; q unchanged.
//  3. Hold load low for 200 cycles -> exactly one card_valid.
//     A second press during busy=1 -> dropped.
//  4. enable=0 with lfsr[3:0]=0, full shoe, press -> card_valid after MAX_TRIES+1 cycles.
//     rank=1, q=1. Repeat after 4 draws -> rank=2.
//  5. Force rank 12 draw -> rank=12, q=10. Force rank 1 -> q=1.
//  6. Assert shuffle in the DRAW cycle -> no card_valid, cards_left=52, state IDLE.
//     reset_n=0 mid-DRAW -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/card_pkg.sv
// Shared types and constants for the card draw unit: FSM encoding, shoe geometry and
// the rank-to-blackjack-value mapping.
package card_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StEmpty
  } state_e;

  localparam int NUM_RANKS      = 13;
  localparam int FACE_VALUE     = 10;
  localparam int CARDS_PER_DECK = 52;

  // Face cards (J, Q, K) all score as ten.
  function automatic logic [4:0] bj_value(input logic [3:0] r);
    return (int'(r) > FACE_VALUE) ? 5'(FACE_VALUE) : {1'b0, r};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11, loaded with a non-zero seed.
module lfsr16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lfsr_q <= seed;
    end else if (enable) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/card_draw_unit.sv
// Draws one card without replacement from a finite shoe per key press, using a free-running
// LFSR with a bounded number of random attempts before falling back to the lowest rank left.
module card_draw_unit
  import card_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned DECK_COUNT = 1,
  parameter int unsigned MAX_TRIES  = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       load,
  input  logic       shuffle,
  output logic [4:0] q,
  output logic [3:0] rank,
  output logic       card_valid,
  output logic       busy,
  output logic       deck_empty,
  output logic [6:0] cards_left
);

  localparam logic [3:0] RANK_FULL = 4'(4 * DECK_COUNT);
  localparam logic [6:0] SHOE_FULL = 7'(CARDS_PER_DECK * int'(DECK_COUNT));

  logic [15:0] lfsr;
  logic        load_s1, load_s2, load_prev;
  logic        shuffle_s1, shuffle_s2;
  logic        press;
  state_e      state;
  logic [3:0]  tries;
  logic [3:0]  count [16];
  logic [15:0] avail;
  logic [3:0]  cand, lowest, pick;
  logic        accept, commit;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (enable),
    .seed   (LFSR_SEED),
    .state  (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:4];
  assign press       = load_prev & ~load_s2;
  assign cand        = lfsr[3:0];

  always_comb begin
    avail = '0;
    for (int i = 1; i <= NUM_RANKS; i++) begin
      avail[i] = (count[i] != 4'd0);
    end
  end

  // Scan downwards so the last hit is the lowest available rank.
  always_comb begin
    lowest = 4'd0;
    for (int i = NUM_RANKS; i >= 1; i--) begin
      if (avail[i]) lowest = 4'(i);
    end
  end

  assign accept = avail[cand];
  assign pick   = accept ? cand : lowest;
  assign commit = (state == StDraw) && (accept || (tries == 4'(MAX_TRIES)));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      load_s1    <= 1'b1;
      load_s2    <= 1'b1;
      load_prev  <= 1'b1;
      shuffle_s1 <= 1'b0;
      shuffle_s2 <= 1'b0;
      state      <= StIdle;
      tries      <= 4'd0;
      q          <= 5'd0;
      rank       <= 4'd0;
      card_valid <= 1'b0;
      busy       <= 1'b0;
      deck_empty <= 1'b0;
      cards_left <= SHOE_FULL;
      for (int i = 0; i < 16; i++) begin
        count[i] <= (i >= 1 && i <= NUM_RANKS) ? RANK_FULL : 4'd0;
      end
    end else begin
      load_s1    <= load;
      load_s2    <= load_s1;
      load_prev  <= load_s2;
      shuffle_s1 <= shuffle;
      shuffle_s2 <= shuffle_s1;
      card_valid <= 1'b0;
      if (shuffle_s2) begin
        // Refill takes priority over any pending press or commit.
        for (int i = 0; i < 16; i++) begin
          count[i] <= (i >= 1 && i <= NUM_RANKS) ? RANK_FULL : 4'd0;
        end
        cards_left <= SHOE_FULL;
        deck_empty <= 1'b0;
        busy       <= 1'b0;
        state      <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            if (press && cards_left != 7'd0) begin
              state <= StDraw;
              tries <= 4'd0;
              busy  <= 1'b1;
            end
          end
          StDraw: begin
            if (commit) begin
              count[pick] <= count[pick] - 4'd1;
              cards_left  <= cards_left - 7'd1;
              rank        <= pick;
              q           <= bj_value(pick);
              card_valid  <= 1'b1;
              busy        <= 1'b0;
              if (cards_left == 7'd1) begin
                state      <= StEmpty;
                deck_empty <= 1'b1;
              end else begin
                state <= StIdle;
              end
            end else begin
              tries <= tries + 4'd1;
            end
          end
          StEmpty: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
